// File: rtl/lsu_mem_port_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store port:
//   - RV32I funct3 width/sign codes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
//   - lsu_state_t : port FSM state {IDLE, REQ, DONE}
//   - funct3_ok() : legal width code for a load or a store
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Stores only have signless widths; loads also have the unsigned forms.
  function automatic logic funct3_ok(input logic write, input logic [2:0] f);
    logic ok;
    case (f)
      LSU_B, LSU_H, LSU_W: ok = 1'b1;
      LSU_BU, LSU_HU:      ok = ~write;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_port_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational load alignment: picks the byte/half/word lane addressed by
// off_i out of the memory word, moves it to bit 0 and sign- or zero-extends
// it according to funct3_i. Unsupported codes yield zero. Also usable by the
// writeback stage.
// Ports:
//   word_i   [31:0] read word from memory
//   off_i    [1:0]  byte offset inside the word (already size-aligned)
//   funct3_i [2:0]  RV32I load width/sign code
//   result_o [31:0] extended load result
// ---------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    case (off_i)
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      2'd3:    byte_v = word_i[31:24];
      default: byte_v = word_i[7:0];
    endcase
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

    result_o = '0;
    case (funct3_i)
      LSU_B:   result_o = {{24{byte_v[7]}}, byte_v};
      LSU_H:   result_o = {{16{half_v[15]}}, half_v};
      LSU_W:   result_o = word_i;
      LSU_BU:  result_o = {24'h0, byte_v};
      LSU_HU:  result_o = {16'h0, half_v};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port
// Load/store port between execute and data memory. Accepts one operation in
// IDLE, issues a word-aligned request in REQ, retires in DONE. Stalls the
// pipeline from the accepting IDLE cycle until DONE.
//
// Memory handshake: mem_req is the request valid; mem_we/mem_addr/mem_be/
// mem_wdata are stable while mem_req is high and mem_ready low. A transfer
// happens in the cycle mem_req && mem_ready, and mem_rdata is valid in that
// same cycle.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ex_valid/write/funct3/addr/wdata  operation from execute
//   lsu_stall             hold the pipeline
//   lsu_rdata/lsu_rvalid  extended load result (writeback select 2'b01)
//   mem_req/we/addr/be/wdata, mem_ready, mem_rdata  memory port
//   dbg_state_o           current FSM state
//   lsu_misalign          misaligned-access pulse (LSU_MISALIGN_TRAP_EN only)
//
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap
// instead of being forced aligned.
// ---------------------------------------------------------------------------
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_write,
  input  logic [2:0]            ex_funct3,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  output logic                  lsu_stall,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_rvalid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output lsu_state_t            dbg_state_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                  lsu_misalign
`endif
);

  lsu_state_t            state_q, state_d;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] ext_data;

  logic [1:0]            ex_off;
  logic [3:0]            ex_be;
  logic [DATA_WIDTH-1:0] ex_wrep;
  logic                  ex_ok;
  logic                  ex_misal;
  logic                  ex_go;
  logic                  capture;
  logic                  done_load;

  // Offset is truncated to the access size, which is what forces a
  // misaligned half/word onto its natural boundary.
  always_comb begin
    ex_off  = 2'b00;
    ex_be   = 4'b1111;
    ex_wrep = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        ex_off  = ex_addr[1:0];
        ex_be   = 4'b0001 << ex_addr[1:0];
        ex_wrep = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        ex_off  = {ex_addr[1], 1'b0};
        ex_be   = 4'b0011 << {ex_addr[1], 1'b0};
        ex_wrep = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ex_ok = funct3_ok(ex_write, ex_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign ex_misal = ex_ok &&
                    (((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                     ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00)));
`else
  assign ex_misal = 1'b0;
`endif

  // Only legal, aligned operations touch memory; everything else retires
  // straight from IDLE to DONE.
  assign ex_go   = ex_ok && !ex_misal;
  assign capture = (state_q == IDLE) && ex_valid;

  // Next state and stall
  always_comb begin
    state_d   = state_q;
    lsu_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          lsu_stall = 1'b1;
          state_d   = ex_go ? REQ : DONE;
        end
      end
      REQ: begin
        lsu_stall = 1'b1;
        if (mem_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else if (capture) begin
      write_q  <= ex_write;
      funct3_q <= ex_funct3;
      off_q    <= ex_off;
      addr_q   <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
      be_q     <= ex_be;
      wdata_q  <= ex_wrep;
      // An unsupported load still retires, with a zero result.
      if (!ex_ok && !ex_write) rdata_q <= '0;
    end else if ((state_q == REQ) && mem_ready && !write_q) begin
      rdata_q <= ext_data;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       misal_q <= 1'b0;
    else if (capture) misal_q <= ex_misal;
  end

  assign lsu_misalign = (state_q == DONE) && misal_q;
  assign done_load    = (state_q == DONE) && !write_q && !misal_q;
`else
  assign done_load    = (state_q == DONE) && !write_q;
`endif

  load_extend u_load_extend (
    .word_i   (mem_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .result_o (ext_data)
  );

  assign mem_req     = (state_q == REQ);
  assign mem_we      = (state_q == REQ) && write_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign lsu_rdata   = rdata_q;
  assign lsu_rvalid  = done_load;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_port
// Scoreboard bench for lsu_mem_port: the driver pushes expected memory
// requests and load results, a monitor pops and compares them whenever the
// DUT presents mem_req&&mem_ready or lsu_rvalid. A behavioural memory
// responder inserts wait cycles. Directed cases then randomized traffic.
// ---------------------------------------------------------------------------
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_write = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = 32'h0;
  logic [31:0] ex_wdata = 32'h0;
  logic        lsu_stall;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  lsu_pkg::lsu_state_t dbg_state;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        lsu_misalign;
  int          exp_mis_cnt = 0;
`endif

  int checks = 0;
  int failures = 0;

  logic [68:0] exp_req_q[$];   // {we, addr, be, wdata (stores only)}
  logic [31:0] exp_rd_q[$];
  logic [31:0] rdata_hold = 32'h0;

  logic [31:0] cur_rdata = 32'h0;
  int          cur_wait = 0;
  int          wait_cnt = 0;

  lsu_mem_port #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_write    (ex_write),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .lsu_stall   (lsu_stall),
    .lsu_rdata   (lsu_rdata),
    .lsu_rvalid  (lsu_rvalid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .dbg_state_o (dbg_state)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .lsu_misalign(lsu_misalign)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model ---------------------------------------------------------
  function automatic logic [31:0] model_load(input logic [2:0] f, input int idx,
                                             input int sz, input logic [31:0] word);
    longint unsigned v;
    v = (longint'(word) >> (8 * idx)) & ((64'd1 << (8 * sz)) - 64'd1);
    if (!f[2] && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input int sz, input int idx);
    int m;
    m = ((1 << sz) - 1) << idx;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] wd);
    if (sz == 1) return wd[7:0] * 32'h0101_0101;
    if (sz == 2) return wd[15:0] * 32'h0001_0001;
    return wd;
  endfunction

  // Memory responder: ready after cur_wait low cycles of mem_req
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      mem_ready = (wait_cnt >= cur_wait);
      wait_cnt  = wait_cnt + 1;
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end
    mem_rdata = mem_ready ? cur_rdata : $urandom();
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got mem_req=1 addr=%0h expected no request", mem_addr);
        end else if (mem_ready) begin
          check("mem_request", {mem_we, mem_addr, mem_be, mem_we ? mem_wdata : 32'h0},
                exp_req_q.pop_front());
        end else begin
          check("mem_hold", {mem_we, mem_addr, mem_be, mem_we ? mem_wdata : 32'h0},
                exp_req_q[0]);
        end
      end
      if (lsu_rvalid) begin
        if (exp_rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%0h expected no rvalid", lsu_rdata);
        end else begin
          rdata_hold = exp_rd_q.pop_front();
          check("lsu_rdata", lsu_rdata, rdata_hold);
        end
      end else begin
        check("rdata_hold", lsu_rdata, rdata_hold);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      if (lsu_misalign) begin
        checks++;
        if (exp_mis_cnt == 0) begin
          failures++;
          $display("FAIL unexpected_misalign: got lsu_misalign=1 expected 0");
        end else begin
          exp_mis_cnt--;
        end
      end
`endif
    end
  end

  // Driver ------------------------------------------------------------------
  task automatic do_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int wt);
    int sz, idx, exp_stall, stalls, cyc;
    logic ok, mis;
    @(negedge clk);
    ex_valid  = 1'b1;
    ex_write  = w;
    ex_funct3 = f;
    ex_addr   = a;
    ex_wdata  = wd;
    cur_rdata = rd;
    cur_wait  = wt;
    ok  = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    sz  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    idx = int'(a[1:0]);
    idx = idx - (idx % sz);
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ok && (idx != int'(a[1:0]));
`endif
    if (ok && !mis) begin
      exp_req_q.push_back({w, a & 32'hFFFF_FFFC, model_be(sz, idx),
                           w ? model_wdata(sz, wd) : 32'h0});
      if (!w) exp_rd_q.push_back(model_load(f, idx, sz, rd));
      exp_stall = 2 + wt;
    end else begin
      if (!w && !mis) exp_rd_q.push_back(32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      if (mis) exp_mis_cnt++;
`endif
      exp_stall = 1;
    end
    #1;
    stalls = 0;
    cyc = 0;
    while (lsu_stall && cyc < 50) begin
      stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    // ex_valid stays high through DONE; the port must ignore it there.
    check("stall_cycles", stalls, exp_stall);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_mem_req",   mem_req,    0);
    check("rst_mem_we",    mem_we,     0);
    check("rst_stall",     lsu_stall,  0);
    check("rst_rvalid",    lsu_rvalid, 0);
    check("rst_mem_addr",  mem_addr,   0);
    check("rst_mem_be",    mem_be,     0);
    check("rst_mem_wdata", mem_wdata,  0);
    check("rst_lsu_rdata", lsu_rdata,  0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Directed cases
    do_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);   // LB
    do_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0);   // LHU
    do_op(1'b1, 3'b000, 32'h0000_0010, 32'h1234_56AB, 32'h0, 3);   // SB, 3 waits
    idle(1);

    // Reset while waiting in REQ
    @(negedge clk);
    ex_valid  = 1'b1;
    ex_write  = 1'b0;
    ex_funct3 = 3'b010;
    ex_addr   = 32'h0000_0040;
    cur_wait  = 50;
    cur_rdata = 32'h1111_2222;
    exp_req_q.push_back({1'b0, 32'h0000_0040, 4'b1111, 32'h0});
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    ex_valid = 1'b0;
    exp_req_q.delete();
    rdata_hold = 32'h0;
    #1;
    check("rst_req_drop",   mem_req,   0);
    check("rst_stall_drop", lsu_stall, 0);
    check("rst_be_clear",   mem_be,    0);
    check("rst_rdata",      lsu_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 3'b010, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 1);   // LW after reset

    do_op(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0BAD_BEEF, 0);   // LW misaligned
    do_op(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h5555_5555, 0);   // unsupported load
    do_op(1'b1, 3'b100, 32'h0000_0104, 32'h7777_7777, 32'h0, 0);   // unsupported store
    do_op(1'b1, 3'b001, 32'h0000_0203, 32'hAAAA_C3D4, 32'h0, 2);   // SH forced align
    do_op(1'b0, 3'b001, 32'h0000_0302, 32'h0, 32'h8001_7FFF, 0);   // LH sign
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
            $urandom(), $urandom(), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(4);

    check("req_queue_empty", exp_req_q.size(), 0);
    check("rd_queue_empty",  exp_rd_q.size(),  0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign_count", exp_mis_cnt, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store port between the execute stage and the data memory. It issues word-aligned memory requests over a valid/ready handshake and generates byte enables and lane-replicated store data. For loads, it extracts and sign- or zero-extends the addressed byte, half or word and returns it as the read-data operand selected by writeback select code 2'b01. It stalls the pipeline for the duration of each access.

## Interface
- DATA_WIDTH, 32, data path width; only 32 is supported
- ADDR_WIDTH, 32, byte address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents a memory operation
- ex_write  in  1  1 = store, 0 = load
- ex_funct3  in  3  RV32I width/sign code
- ex_addr  in  ADDR_WIDTH  byte address
- ex_wdata  in  DATA_WIDTH  store data, unshifted
- lsu_stall  out  1  hold the pipeline
- lsu_rdata  out  DATA_WIDTH  extended load result, the writeback select 2'b01 operand
- lsu_rvalid  out  1  one-cycle pulse, lsu_rdata updated
- mem_req  out  1  request valid
- mem_we  out  1  write request
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_ready  in  1  memory accepts the request; read data is valid in the same cycle
- mem_rdata  in  DATA_WIDTH  read word
- lsu_misalign  out  1  misaligned-access pulse; exists only with LSU_MISALIGN_TRAP_EN

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If ex_valid, latch write, funct3, addr and wdata, then go to REQ.
  - lsu_stall is asserted combinationally in this cycle.
- REQ:
  - mem_req = 1; mem_we, mem_addr, mem_be and mem_wdata are driven from the latched values and held stable until mem_ready is sampled high.
  - lsu_stall = 1.
  - On mem_ready, go to DONE.
  - For a load, also capture the extended result into lsu_rdata.
- DONE:
  - lsu_stall = 0. lsu_rvalid = 1 for loads only.
  - ex_valid is ignored, because it still carries the retiring operation.
  - Always go to IDLE.
- Width codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Byte enables:
  - Byte access: mem_be = 4'b0001 << addr[1:0].
  - Half access: mem_be = 4'b0011 << {addr[1],1'b0}.
  - Word access: mem_be = 4'b1111.
- Store data: SB drives {4{wdata[7:0]}}; SH drives {2{wdata[15:0]}}; SW drives wdata.
- Load extraction:
  - The selected lane is shifted to bit 0.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Unsupported funct3 (011, 110, 111, and stores with 1xx):
  - No mem_req is issued; REQ is skipped and the FSM goes IDLE→DONE.
  - For a load, lsu_rdata = 0 and lsu_rvalid pulses.
- Misaligned accesses without the macro: the address is forced aligned to the access size (LH at 0x3 accesses 0x2).
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - mem_req, mem_we, lsu_stall, lsu_rvalid and lsu_misalign go to 0; mem_addr, mem_be, mem_wdata and lsu_rdata go to 0.
  - An in-flight request is abandoned with no completion.

## Timing
- Load with mem_ready high on first REQ cycle:
  - Cycle 0: IDLE, stall.
  - Cycle 1: REQ, stall.
  - Cycle 2: DONE, rvalid, no stall.
  - Total: 3 cycles, 2 stall cycles.
- Each cycle mem_ready is low in REQ adds one cycle.
- Stores follow the same timing with no rvalid.
- lsu_rdata holds its value until the next completed load.
- A back-to-back operation is accepted in the IDLE cycle after DONE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned cases are LH/LHU/SH with addr[0] = 1, and LW/SW with addr[1:0] != 0.
  - A misaligned access goes IDLE→DONE with no mem_req.
  - lsu_misalign pulses in DONE; lsu_rvalid stays low; lsu_rdata is unchanged.
- LSU_MISALIGN_TRAP_EN undefined: the lsu_misalign port is absent and the address is forced aligned as above.

## Structure
- lsu_pkg: funct3 width constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) and the state enum lsu_state_t {IDLE, REQ, DONE}.
- Sub-module load_extend: combinational; inputs are the word, addr[1:0] and funct3; output is the extended result. It is reusable by the writeback stage.

## Test plan
- LB at 0x1003, mem_rdata 0x80FF_0000, mem_ready immediate:
  - mem_addr = 0x1000, mem_be = 4'b1000.
  - lsu_rdata = 0xFFFF_FF80 on cycle 2; stall high on cycles 0–1 only.
- LHU at 0x2002, mem_rdata 0xBEEF_1234: lsu_rdata = 0x0000_BEEF.
- SB at 0x10, wdata 0x1234_56AB, mem_ready low for 3 cycles:
  - mem_wdata = 0xABAB_ABAB and mem_be = 4'b0001, both held stable during the wait.
  - No rvalid.
- Reset asserted in REQ while mem_ready is low: mem_req and lsu_stall drop immediately; after release, the next LW issues normally.
- LW at 0x6 with LSU_MISALIGN_TRAP_EN: no mem_req; lsu_misalign pulses once; lsu_rdata is unchanged. Without the macro: mem_addr = 0x4, mem_be = 4'b1111.
- funct3 = 011 load: no mem_req; lsu_rdata = 0 with an rvalid pulse on cycle 1.
